// File: rtl/cicero_job_loader.sv
// Job sequencer in front of the CICERO AXI_top register file: streams code/string words
// into memory, runs the engine and returns one result per job. JOB_TIMEOUT_EN bounds WAIT.
module cicero_job_loader #(
    parameter int REG_WIDTH  = 32,
    parameter int CC_ID_BITS = 2,
    parameter int START_HOLD = 2
`ifdef JOB_TIMEOUT_EN
    ,parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_WIDTH-1:0] in_data,
    input  logic                 in_is_string,
    input  logic [2:0]           in_bytes,
    input  logic                 in_last,
    output logic [REG_WIDTH-1:0] data_in_register,
    output logic [REG_WIDTH-1:0] address_register,
    output logic [REG_WIDTH-1:0] start_cc_pointer_register,
    output logic [REG_WIDTH-1:0] end_cc_pointer_register,
    output logic [REG_WIDTH-1:0] cmd_register,
    input  logic [REG_WIDTH-1:0] status_register,
    input  logic [REG_WIDTH-1:0] data_o_register,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_accept,
    output logic [REG_WIDTH-1:0] res_cc,
    output logic                 res_error,
    output logic                 busy
);
    localparam logic [REG_WIDTH-1:0] CMD_NOP                = REG_WIDTH'(0);
    localparam logic [REG_WIDTH-1:0] CMD_WRITE              = REG_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] CMD_START              = REG_WIDTH'(3);
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = REG_WIDTH'(5);
    localparam logic [REG_WIDTH-1:0] STATUS_RUNNING         = REG_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED        = REG_WIDTH'(2);
    localparam logic [REG_WIDTH-1:0] STATUS_REJECTED        = REG_WIDTH'(3);
    localparam logic [REG_WIDTH-1:0] ALIGN_MASK = REG_WIDTH'((64'd1 << CC_ID_BITS) - 64'd1);
    localparam logic [31:0]          HOLD_LAST  = 32'(START_HOLD - 1);
`ifdef JOB_TIMEOUT_EN
    localparam logic [31:0]          TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WRITE, S_ALIGN, S_START, S_CHECK, S_WAIT, S_READ_CC, S_CAPTURE, S_RESULT
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic [REG_WIDTH-1:0] r_data, r_addr, r_start_ptr, r_end_ptr, r_cmd, r_res_cc;
    logic                 r_res_valid, r_res_accept, r_res_error;
    logic [REG_WIDTH-1:0] r_byte_addr, r_str_start, r_inc;
    logic                 r_last, r_seen_str, r_err;
    logic [31:0]          r_cnt;

    logic [2:0]           w_bytes;
    logic                 w_bytes_bad;
    logic [REG_WIDTH-1:0] w_data, w_aligned, w_wr_addr;
    logic                 w_first_str;

    // Out-of-range byte counts write a full word but poison the job.
    always_comb begin
        w_bytes     = in_bytes;
        w_bytes_bad = 1'b0;
        if (in_bytes == 3'd0 || in_bytes > 3'd4) begin
            w_bytes     = 3'd4;
            w_bytes_bad = 1'b1;
        end
        w_data = in_data;
        for (int b = 0; b < REG_WIDTH / 8; b++)
            if (in_is_string && b >= int'(w_bytes)) w_data[b*8 +: 8] = 8'h00;
    end

    assign w_aligned   = (r_byte_addr + ALIGN_MASK) & ~ALIGN_MASK;
    assign w_first_str = in_is_string && !r_seen_str;
    assign w_wr_addr   = w_first_str ? w_aligned : r_byte_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_cmd        <= CMD_NOP;
            r_data       <= '0;
            r_addr       <= '0;
            r_start_ptr  <= '0;
            r_end_ptr    <= '0;
            r_res_valid  <= 1'b0;
            r_res_accept <= 1'b0;
            r_res_cc     <= '0;
            r_res_error  <= 1'b0;
            r_byte_addr  <= '0;
            r_str_start  <= '0;
            r_inc        <= '0;
            r_last       <= 1'b0;
            r_seen_str   <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        if (!in_is_string && r_seen_str) begin
                            r_err <= 1'b1;
                            if (in_last) begin
                                r_in_ready <= 1'b0;
                                r_state    <= S_ALIGN;
                            end else begin
                                r_state    <= S_LOAD;
                            end
                        end else begin
                            r_in_ready  <= 1'b0;
                            r_state     <= S_WRITE;
                            r_cmd       <= CMD_WRITE;
                            r_data      <= w_data;
                            r_addr      <= w_wr_addr >> 2;
                            r_byte_addr <= w_wr_addr;
                            r_last      <= in_last;
                            r_inc       <= in_is_string ? REG_WIDTH'(w_bytes) : REG_WIDTH'(4);
                            if (in_is_string && w_bytes_bad) r_err <= 1'b1;
                            if (w_first_str) begin
                                r_seen_str  <= 1'b1;
                                r_str_start <= w_aligned;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    r_cmd       <= CMD_NOP;
                    r_byte_addr <= r_byte_addr + r_inc;
                    r_in_ready  <= !r_last;
                    r_state     <= r_last ? S_ALIGN : S_LOAD;
                end
                S_ALIGN: begin
                    if (!r_seen_str) begin
                        r_err        <= 1'b1;
                        r_res_error  <= 1'b1;
                        r_res_accept <= 1'b0;
                        r_res_cc     <= '0;
                        r_res_valid  <= 1'b1;
                        r_state      <= S_RESULT;
                    end else begin
                        r_start_ptr <= r_str_start;
                        r_end_ptr   <= r_byte_addr - REG_WIDTH'(1);
                        r_cmd       <= CMD_START;
                        r_cnt       <= '0;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == HOLD_LAST) r_state <= S_CHECK;
                    else                    r_cnt   <= r_cnt + 32'd1;
                end
                S_CHECK: begin
                    r_cmd <= CMD_NOP;
                    r_cnt <= '0;
                    if (status_register != STATUS_RUNNING) begin
                        r_err        <= 1'b1;
                        r_res_error  <= 1'b1;
                        r_res_accept <= 1'b0;
                        r_res_cc     <= '0;
                        r_res_valid  <= 1'b1;
                        r_state      <= S_RESULT;
                    end else begin
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (status_register == STATUS_RUNNING) begin
`ifdef JOB_TIMEOUT_EN
                        if (r_cnt == TO_LAST) begin
                            r_err        <= 1'b1;
                            r_res_accept <= 1'b0;
                            r_cmd        <= CMD_NOP;
                            r_state      <= S_READ_CC;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
`endif
                    end else begin
                        r_res_accept <= (status_register == STATUS_ACCEPTED);
                        if (status_register != STATUS_ACCEPTED && status_register != STATUS_REJECTED)
                            r_err <= 1'b1;
                        r_state <= S_READ_CC;
                    end
                end
                S_READ_CC: begin
                    r_cmd   <= CMD_READ_ELAPSED_CLOCK;
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_res_cc    <= data_o_register;
                    r_cmd       <= CMD_NOP;
                    r_res_error <= r_err;
                    r_res_valid <= 1'b1;
                    r_state     <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_byte_addr <= '0;
                        r_err       <= 1'b0;
                        r_seen_str  <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready                  = r_in_ready;
    assign data_in_register          = r_data;
    assign address_register          = r_addr;
    assign start_cc_pointer_register = r_start_ptr;
    assign end_cc_pointer_register   = r_end_ptr;
    assign cmd_register              = r_cmd;
    assign res_valid                 = r_res_valid;
    assign res_accept                = r_res_accept;
    assign res_cc                    = r_res_cc;
    assign res_error                 = r_res_error;
    assign busy                      = (r_state != S_IDLE);
endmodule
